bus_arbitro_micro: RTL

- Two-master arbiter and bus-cycle sequencer for the micro's 8-bit data/address bus.
- Grants the bus to one requester (0 = core datapath, 1 = auxiliary/DMA port) on a round-robin basis.
- Latches the winner's address, data and direction, then runs a fixed address/data/response cycle with a ready handshake and a timeout.
- Sits between the register/operand sources and the memory/peripheral side of the bus.

---
 rtl/bus_arbitro_micro_if.sv | 34 +++
 rtl/bus_arbitro_micro.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bus_arbitro_micro_if.sv
// Bus bundle between the two requesters, the arbiter/sequencer and the slave side.
interface bus_arbitro_micro_if #(
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        req;
    logic              rw0;
    logic              rw1;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rw;
    logic              bus_valid;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    // Requesters plus memory/peripheral side
    modport master (
        output req, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_ready, bus_rdata,
        input  gnt, done, err, rdata, bus_addr, bus_wdata, bus_rw, bus_valid
    );

    // Arbiter/sequencer side
    modport slave (
        input  req, rw0, rw1, addr0, addr1, wdata0, wdata1, bus_ready, bus_rdata,
        output gnt, done, err, rdata, bus_addr, bus_wdata, bus_rw, bus_valid
    );
endinterface

// File: rtl/bus_arbitro_micro.sv
// Two-master round-robin arbiter running a fixed ADDR/DATA/RESP bus cycle
// with a ready handshake and a bounded wait.
module bus_arbitro_micro #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WAIT_MAX = 15
) (
    input logic               clk,
    input logic               rst,
    bus_arbitro_micro_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state, state_n;
    logic [1:0]        gnt_q, gnt_n;
    logic [1:0]        done_q, done_n;
    logic [1:0]        err_q, err_n;
    logic              last_q, last_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [DATA_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              rw_q, rw_n;
    logic              valid_q, valid_n;
    logic              win_c;

    // Sole requester wins; a tie goes to the one that was not served last
    always_comb begin
        win_c = 1'b0;
        case (bus.req)
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = ~last_q;
            default: win_c = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        done_n  = 2'b00;
        err_n   = 2'b00;
        last_n  = last_q;
        cnt_n   = cnt_q;
        rdata_n = rdata_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rw_n    = rw_q;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_n = ADDR;
                    gnt_n   = win_c ? 2'b10 : 2'b01;
                    last_n  = win_c;
                    addr_n  = win_c ? bus.addr1  : bus.addr0;
                    wdata_n = win_c ? bus.wdata1 : bus.wdata0;
                    rw_n    = win_c ? bus.rw1    : bus.rw0;
                    valid_n = 1'b1;
                end
            end
            ADDR: begin
                state_n = DATA;
                cnt_n   = '0;
                valid_n = 1'b1;
            end
            DATA: begin
                valid_n = 1'b1;
                if (bus.bus_ready) begin
                    state_n = RESP;
                    valid_n = 1'b0;
                    done_n  = last_q ? 2'b10 : 2'b01;
                    if (rw_q) rdata_n = bus.bus_rdata;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_n = RESP;
                    valid_n = 1'b0;
                    err_n   = last_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            gnt_q   <= gnt_n;
            done_q  <= done_n;
            err_q   <= err_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
            rdata_q <= rdata_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rw_q    <= rw_n;
            valid_q <= valid_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_rw    = rw_q;
    assign bus.bus_valid = valid_q;
endmodule
